// File: rtl/cgra_kernel_scheduler.sv
// cgra_kernel_scheduler
// Queues CGRA kernel descriptors in a small FIFO and runs them back-to-back:
// configuration load (skipped when the bitstream is already resident), then
// input/output stream execution, then a completion record with tag and cycle
// count.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid, once raised, is held with its payload stable until the
// transfer; ready may change freely and never depends on valid.
// desc_valid_i/desc_ready_o and cmpl_valid_o/cmpl_ready_i follow this rule.
module cgra_kernel_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             desc_valid_i,
  output logic             desc_ready_o,
  input  logic [31:0]      desc_cfg_addr_i,
  input  logic [15:0]      desc_cfg_size_i,
  input  logic [TAG_W-1:0] desc_tag_i,
  output logic [31:0]      data_config_addr_o,
  output logic [15:0]      data_config_size_o,
  output logic             execute_config_o,
  output logic             execute_input_o,
  output logic             execute_output_o,
  input  logic             data_config_done_i,
  input  logic             data_output_done_i,
  output logic             cmpl_valid_o,
  input  logic             cmpl_ready_i,
  output logic [TAG_W-1:0] cmpl_tag_o,
  output logic [31:0]      cmpl_cycles_o,
  input  logic             invalidate_cfg_i,
  input  logic             abort_i,
  output logic             clear_cgra_o,
  output logic             busy_o,
  output logic [15:0]      jobs_done_o,
  output logic [15:0]      cfg_skips_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CHECK      = 3'd1,
    S_CFG_START  = 3'd2,
    S_CFG_WAIT   = 3'd3,
    S_EXEC_START = 3'd4,
    S_EXEC_WAIT  = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t state_q;

  // Descriptor storage and bookkeeping
  logic [31:0]      addr_mem [DEPTH];
  logic [15:0]      size_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // Resident configuration tracking
  logic             cfg_loaded_q;
  logic [31:0]      last_addr_q;
  logic [15:0]      last_size_q;
  logic [TAG_W-1:0] cur_tag_q;
  logic             cfg_hit;

  // Full blocks a push even when a pop happens in the same cycle.
  assign desc_ready_o = (count_q < FULL_CNT);
  // Abort drops any push or pop offered in its cycle.
  assign push   = desc_valid_i & desc_ready_o & ~abort_i;
  assign pop    = (state_q == S_IDLE) & (count_q != '0) & ~abort_i;
  assign busy_o = (state_q != S_IDLE) | (count_q != '0);

  // A coincident invalidate forces a miss.
  assign cfg_hit = cfg_loaded_q & ~invalidate_cfg_i &
                   (data_config_addr_o == last_addr_q) &
                   (data_config_size_o == last_size_q);

  assign cmpl_tag_o = cur_tag_q;

  // Descriptor payload write port; no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= desc_cfg_addr_i;
      size_mem[wr_ptr_q] <= desc_cfg_size_i;
      tag_mem[wr_ptr_q]  <= desc_tag_i;
    end
  end

  // FIFO pointers and occupancy; abort empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Job sequencer: state, registered pulses, completion record and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= S_IDLE;
      cfg_loaded_q       <= 1'b0;
      last_addr_q        <= '0;
      last_size_q        <= '0;
      cur_tag_q          <= '0;
      data_config_addr_o <= '0;
      data_config_size_o <= '0;
      execute_config_o   <= 1'b0;
      execute_input_o    <= 1'b0;
      execute_output_o   <= 1'b0;
      cmpl_valid_o       <= 1'b0;
      cmpl_cycles_o      <= '0;
      clear_cgra_o       <= 1'b0;
      jobs_done_o        <= '0;
      cfg_skips_o        <= '0;
    end else begin
      execute_config_o <= 1'b0;
      execute_input_o  <= 1'b0;
      execute_output_o <= 1'b0;
      clear_cgra_o     <= 1'b0;
      if (abort_i) begin
        state_q      <= S_IDLE;
        cfg_loaded_q <= 1'b0;
        cmpl_valid_o <= 1'b0;
        clear_cgra_o <= 1'b1;
      end else begin
        // Job latency runs from CHECK up to the DONE entry, saturating.
        if ((state_q != S_IDLE) && (state_q != S_DONE) && (cmpl_cycles_o != '1)) begin
          cmpl_cycles_o <= cmpl_cycles_o + 32'd1;
        end
        case (state_q)
          S_IDLE: begin
            if (pop) begin
              data_config_addr_o <= addr_mem[rd_ptr_q];
              data_config_size_o <= size_mem[rd_ptr_q];
              cur_tag_q          <= tag_mem[rd_ptr_q];
              cmpl_cycles_o      <= '0;
              state_q            <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (cfg_hit) begin
              cfg_skips_o      <= cfg_skips_o + 16'd1;
              execute_input_o  <= 1'b1;
              execute_output_o <= 1'b1;
              state_q          <= S_EXEC_START;
            end else begin
              execute_config_o <= 1'b1;
              state_q          <= S_CFG_START;
            end
          end
          S_CFG_START: state_q <= S_CFG_WAIT;
          S_CFG_WAIT: begin
            if (data_config_done_i) begin
              last_addr_q      <= data_config_addr_o;
              last_size_q      <= data_config_size_o;
              cfg_loaded_q     <= 1'b1;
              execute_input_o  <= 1'b1;
              execute_output_o <= 1'b1;
              state_q          <= S_EXEC_START;
            end
          end
          S_EXEC_START: state_q <= S_EXEC_WAIT;
          S_EXEC_WAIT: begin
            if (data_output_done_i) begin
              cmpl_valid_o <= 1'b1;
              state_q      <= S_DONE;
            end
          end
          S_DONE: begin
            if (cmpl_ready_i) begin
              cmpl_valid_o <= 1'b0;
              jobs_done_o  <= jobs_done_o + 16'd1;
              state_q      <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
        // Invalidate overrides a load completing in the same cycle.
        if (invalidate_cfg_i) cfg_loaded_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cgra_kernel_scheduler.md
# cgra_kernel_scheduler

Queues CGRA kernel descriptors (configuration bitstream address/size plus a job tag) and runs them back-to-back on the CGRA datapath. For each job it issues the configuration load, then the input/output execution, and reports completion. It skips the configuration load when the requested bitstream is already resident. It sits between the CSR block and the CGRA load/stream state machines, replacing direct CSR-driven start pulses.

## Interface
Parameters:
- DEPTH, 4 — descriptor FIFO entries; power of two, ≥2.
- TAG_W, 8 — job tag width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- desc_valid_i  in  1  descriptor offered.
- desc_ready_o  out  1  FIFO can accept; equals (count < DEPTH).
- desc_cfg_addr_i  in  32  bitstream address.
- desc_cfg_size_i  in  16  bitstream size.
- desc_tag_i  in  TAG_W  job tag.
- data_config_addr_o  out  32  current job's bitstream address, held from CHECK until the next pop.
- data_config_size_o  out  16  current job's bitstream size, same hold rule.
- execute_config_o  out  1  one-cycle config-load start pulse.
- execute_input_o  out  1  one-cycle input-stream start pulse.
- execute_output_o  out  1  one-cycle output-stream start pulse; asserted in the same cycle as execute_input_o.
- data_config_done_i  in  1  config load finished (pulse or level).
- data_output_done_i  in  1  output streams finished (pulse or level).
- cmpl_valid_o  out  1  job completed.
- cmpl_ready_i  in  1  completion consumed.
- cmpl_tag_o  out  TAG_W  tag of the completed job.
- cmpl_cycles_o  out  32  cycles from CHECK to DONE entry, saturating.
- invalidate_cfg_i  in  1  forget the resident configuration.
- abort_i  in  1  flush and return to idle.
- clear_cgra_o  out  1  one-cycle CGRA clear pulse on abort.
- busy_o  out  1  state != IDLE or count != 0.
- jobs_done_o  out  16  completed-job counter, wraps.
- cfg_skips_o  out  16  skipped-config-load counter, wraps.

## Operation
- FIFO
  - Registered FIFO; push = desc_valid_i & desc_ready_o.
  - desc_ready_o is low whenever the FIFO is full, even in a cycle with a pop.
  - Push and pop may occur in the same cycle when not full; count is unchanged.
- State machine: IDLE, CHECK, CFG_START, CFG_WAIT, EXEC_START, EXEC_WAIT, DONE.
- IDLE: if count > 0, pop the head into the current-job registers and go to CHECK.
- CHECK:
  - Hit when cfg_loaded_q & (addr == last_addr_q) & (size == last_size_q): increment cfg_skips_o, go to EXEC_START.
  - Otherwise go to CFG_START.
- CFG_START: execute_config_o = 1; go to CFG_WAIT.
- CFG_WAIT: on data_config_done_i, set last_addr_q/last_size_q, set cfg_loaded_q = 1, go to EXEC_START.
- EXEC_START: execute_input_o = execute_output_o = 1; go to EXEC_WAIT.
- EXEC_WAIT: on data_output_done_i, go to DONE.
- DONE:
  - cmpl_valid_o = 1, with tag and cycles stable.
  - On cmpl_ready_i: increment jobs_done_o, go to IDLE.
- Cycle counter: cleared on CHECK entry, +1 each cycle until DONE entry, saturates at 0xFFFFFFFF.
- Done inputs are ignored outside their wait states. A level still high from a previous job is consumed only in the correct wait state, so done sources must deassert by the next start pulse.
- invalidate_cfg_i clears cfg_loaded_q. If it coincides with a CHECK cycle, invalidate wins and the job takes a miss.
- abort_i (any state)
  - Next cycle: FIFO empty, state IDLE, cfg_loaded_q = 0.
  - clear_cgra_o = 1 for exactly that one cycle.
  - No completion is reported for the aborted job.
  - A push in the abort cycle is dropped.
  - Abort has priority over every other event.
- jobs_done_o and cfg_skips_o are not cleared by abort.

## Timing
- Reset values
  - Outputs: desc_ready_o = 1; every pulse/valid output 0; busy_o 0; address, size, tag, cycles and counters all 0.
  - Internal: cfg_loaded_q = 0, state IDLE.
- Empty idle scheduler, push in cycle 0:
  - count = 1 in cycle 1, popped in cycle 1; CHECK in cycle 2.
  - Miss: execute_config_o in cycle 3.
  - Hit: execute_input_o/execute_output_o in cycle 3.
- Config done sampled in cycle k (CFG_WAIT) → start pulses in cycle k+1.
- Output done sampled in cycle m → cmpl_valid_o from cycle m+1.
- cmpl_ready_i high in DONE cycle d → next job's CHECK no earlier than d+2.
- Start pulses are never asserted for two consecutive cycles.

## Test plan
- Single miss job: push {addr 0x8000_0000, size 16, tag 0x01}; config done 5 cycles after execute_config_o, output done 10 cycles after execute_input_o → one config pulse in cycle 3, cmpl_tag_o = 0x01, cmpl_cycles_o = 18, jobs_done_o = 1.
- Config reuse: two jobs with the same addr/size, tags 1 and 2 → second job has no execute_config_o, starts EXEC 1 cycle after CHECK, cfg_skips_o = 1; with invalidate_cfg_i pulsed between the jobs, the second job reloads and cfg_skips_o = 0.
- FIFO full: DEPTH = 4, scheduler held in EXEC_WAIT, push 5 descriptors back-to-back → 4 accepted, desc_ready_o low from the cycle after the 4th push; the remaining jobs complete in FIFO order with tags preserved.
- Completion backpressure: cmpl_ready_i held low for 20 cycles → cmpl_valid_o, cmpl_tag_o and cmpl_cycles_o stable throughout; the next job does not start.
- Abort mid-config: abort_i in CFG_WAIT with 2 jobs queued → clear_cgra_o pulses once, busy_o = 0 next cycle, no completion; a later data_config_done_i is ignored; the next pushed job takes a miss.
- Async reset mid-EXEC_WAIT: assert rst_ni low asynchronously → all outputs at reset values immediately; after release the FIFO is empty and the next job takes a miss.
